// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions for the message-schedule slice:
//   - word / index / block widths
//   - small-sigma rotate and shift amounts (sigma0: 7,18,3; sigma1: 17,19,10)
//   - round-constant table K, consumed by the downstream compression block
//   - schedule FSM state enum
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int IDX_W   = 6;
    localparam int BLOCK_W = 512;
    localparam int WIN_LEN = 16;

    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    localparam logic [WORD_W-1:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if
// Bundles the block-load handshake and the schedule-word stream.
//   start/start_ready/block_in : load one padded 512-bit block
//   w_out/w_idx/w_valid/w_ready: valid/ready stream of W[t]
//   done                        : one-cycle pulse after the last word
// master = block producer / word consumer side, slave = schedule generator.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic                 start;
    logic                 start_ready;
    logic [BLOCK_W-1:0]   block_in;
    logic [WORD_W-1:0]    w_out;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_valid;
    logic                 w_ready;
    logic                 done;

    modport master (
        output start, block_in, w_ready,
        input  start_ready, w_out, w_idx, w_valid, done
    );

    modport slave (
        input  start, block_in, w_ready,
        output start_ready, w_out, w_idx, w_valid, done
    );

endinterface

// File: rtl/rotr.sv
// rotr
// Constant-amount rotate right of a W-bit word.
//   x : input word
//   y : x rotated right by N bit positions
module rotr #(
    parameter int W = 32,
    parameter int N = 1
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = (x >> N) | (x << (W - N));

endmodule

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma
// SHA-256 small sigma: ROTR(ROT_A) ^ ROTR(ROT_B) ^ SHR(SHR).
//   x : input word
//   y : sigma(x)
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int ROT_A = S0_ROT_A,
    parameter int ROT_B = S0_ROT_B,
    parameter int SHR   = S0_SHR
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    logic [WORD_W-1:0] rot_a;
    logic [WORD_W-1:0] rot_b;

    rotr #(.W(WORD_W), .N(ROT_A)) u_rot_a (.x(x), .y(rot_a));
    rotr #(.W(WORD_W), .N(ROT_B)) u_rot_b (.x(x), .y(rot_b));

    assign y = rot_a ^ rot_b ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Streams W[0..NUM_WORDS-1] of the SHA-256 message schedule for one padded
// block, one word per accepted beat, using a 16-word sliding window.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sha256_msg_schedule_if (load handshake,
//              word stream, done pulse)
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_schedule_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  window_q [WIN_LEN];
    logic [WORD_W-1:0]  window_d [WIN_LEN];
    logic [IDX_W-1:0]   t_q, t_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  sig0;
    logic [WORD_W-1:0]  sig1;
    logic [WORD_W-1:0]  new_word;
    logic               accept;

    // window[1] is W[t+1] and window[14] is W[t+14], i.e. W[j-15] and W[j-2]
    // for the word j = t+16 being produced.
    sha256_small_sigma #(.ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR(S0_SHR))
        u_sigma0 (.x(window_q[1]), .y(sig0));

    sha256_small_sigma #(.ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR(S1_SHR))
        u_sigma1 (.x(window_q[14]), .y(sig1));

    // Single-cycle four-operand adder; carries beyond 32 bits are dropped.
    assign new_word = sig1 + window_q[9] + sig0 + window_q[0];
    assign accept   = (state_q == RUN) && bus.w_ready;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        t_d      = t_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < WIN_LEN; i++) begin
                        window_d[i] = bus.block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
                    end
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    for (int i = 0; i < WIN_LEN - 1; i++) begin
                        window_d[i] = window_q[i+1];
                    end
                    window_d[WIN_LEN-1] = new_word;
                    t_d = t_q + 1'b1;
                    if (t_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < WIN_LEN; i++) begin
                window_q[i] <= '0;
            end
            t_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            t_q      <= t_d;
            done_q   <= done_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.w_valid     = (state_q == RUN);
    assign bus.w_out       = window_q[0];
    assign bus.w_idx       = t_q;
    assign bus.done        = done_q;

endmodule
